// File: rtl/histogram_pkg.sv
// Shared types and default constants for the histogram run sequencer.
package histogram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIG  = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_READOUT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int DEF_CHANNEL_WIDTH = 6;
    localparam int DEF_SHIFT_WIDTH   = 6;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_BIN_COUNT     = 4096;
    localparam int DEF_CLEAR_CYCLES  = 4096;
    localparam int DEF_TIMEOUT       = 65535;

    // A zero-length phase still occupies one cycle.
    function automatic logic [31:0] at_least_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; expire_o marks the final cycle of a loaded interval.
module seq_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over counting; the counter parks at zero once exhausted.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/histogram_sequencer.sv
// Sequences a histogram core through config, clear, acquire and readout,
// forwarding readout beats with bin indices and tracking completed frames.
module histogram_sequencer
    import histogram_pkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int SHIFT_WIDTH   = DEF_SHIFT_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int BIN_COUNT     = DEF_BIN_COUNT,
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    localparam int IDX_W        = $clog2(BIN_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     continuous_i,
    input  logic [CHANNEL_WIDTH-1:0] cfg_click_channel_i,
    input  logic [CHANNEL_WIDTH-1:0] cfg_start_channel_i,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift_i,
    input  logic [31:0]              cfg_acq_cycles_i,
    output logic                     hist_config_en_o,
    output logic [CHANNEL_WIDTH-1:0] hist_click_channel_o,
    output logic [CHANNEL_WIDTH-1:0] hist_start_channel_o,
    output logic [SHIFT_WIDTH-1:0]   hist_shift_val_o,
    output logic                     hist_reset_o,
    output logic                     hist_read_start_o,
    input  logic [DATA_WIDTH-1:0]    hist_data_i,
    input  logic                     hist_valid_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic [IDX_W-1:0]         out_index_o,
    output logic                     out_valid_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     error_o,
    output logic [31:0]              frame_count_o
);

    state_e state_q, state_d;
    logic   entry_q;

    logic [CHANNEL_WIDTH-1:0] click_q, startch_q;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic [31:0]              acq_q;
    logic                     cont_q;

    logic [IDX_W-1:0]      beat_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0]      out_index_q;
    logic                  out_valid_q, out_last_q;
    logic                  err_q;
    logic [31:0]           frame_cnt_q;

    logic        tmr_load, tmr_expire;
    logic [31:0] tmr_val;

    logic start_go, beat, last_beat, timeout;

    assign start_go  = (state_q == ST_IDLE) && start_i && !abort_i;
    assign beat      = (state_q == ST_READOUT) && hist_valid_i && !abort_i;
    assign last_beat = beat && (beat_q == IDX_W'(BIN_COUNT - 1));
    assign timeout   = (state_q == ST_READOUT) && !hist_valid_i && tmr_expire && !abort_i;

    seq_timer #(.W(32)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // State register plus a flag marking the first cycle spent in a state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_CONFIG;
            ST_CONFIG:  state_d = ST_CLEAR;
            ST_CLEAR:   if (tmr_expire) state_d = ST_ACQUIRE;
            ST_ACQUIRE: if (tmr_expire) state_d = ST_READOUT;
            ST_READOUT: begin
                if (last_beat)    state_d = ST_DONE;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_DONE:    state_d = cont_q ? ST_CLEAR : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // Timer reload on every phase entry and on each readout beat (idle watchdog).
    always_comb begin
        tmr_load = (state_d != state_q) || beat;
        unique case (state_d)
            ST_CLEAR:   tmr_val = at_least_one(32'(CLEAR_CYCLES));
            ST_ACQUIRE: tmr_val = at_least_one(acq_q);
            ST_READOUT: tmr_val = at_least_one(32'(TIMEOUT));
            default:    tmr_val = 32'd0;
        endcase
    end

    // Moore strobes, suppressed in the cycle an abort is seen.
    always_comb begin
        hist_config_en_o  = (state_q == ST_CONFIG) && !abort_i;
        hist_reset_o      = (state_q == ST_CLEAR) && entry_q && !abort_i;
        hist_read_start_o = (state_q == ST_READOUT) && entry_q && !abort_i;
        frame_done_o      = (state_q == ST_DONE) && !abort_i;
        busy_o            = (state_q != ST_IDLE);
    end

    // Run configuration captured at start and held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_q   <= '0;
            startch_q <= '0;
            shift_q   <= '0;
            acq_q     <= '0;
            cont_q    <= 1'b0;
        end else if (start_go) begin
            click_q   <= cfg_click_channel_i;
            startch_q <= cfg_start_channel_i;
            shift_q   <= cfg_shift_i;
            acq_q     <= cfg_acq_cycles_i;
            cont_q    <= continuous_i;
        end
    end

    // Beat index, one-cycle readout forwarding, error flag and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (state_q != ST_READOUT) beat_q <= '0;
            else if (beat)             beat_q <= beat_q + IDX_W'(1);
            out_valid_q <= beat;
            out_last_q  <= last_beat;
            if (beat) begin
                out_data_q  <= hist_data_i;
                out_index_q <= beat_q;
            end
            if (timeout)       err_q <= 1'b1;
            else if (start_go) err_q <= 1'b0;
            if (frame_done_o)  frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign hist_click_channel_o = click_q;
    assign hist_start_channel_o = startch_q;
    assign hist_shift_val_o     = shift_q;
    assign out_data_o           = out_data_q;
    assign out_index_o          = out_index_q;
    assign out_valid_o          = out_valid_q;
    assign out_last_o           = out_last_q;
    assign error_o              = err_q;
    assign frame_count_o        = frame_cnt_q;

endmodule

// File: tb/tb_histogram_sequencer.sv
// Directed bench: single frame timing, continuous mode, abort, readout
// timeout, zero-length acquire and reset during readout.
module tb_histogram_sequencer;

    localparam int CW = 6, SW = 6, DW = 32, BINS = 8, CLR = 4, TMO = 20;
    localparam int IW = $clog2(BINS);

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start_i = 0, abort_i = 0, continuous_i = 0;
    logic [CW-1:0] cfg_click_channel_i = '0, cfg_start_channel_i = '0;
    logic [SW-1:0] cfg_shift_i = '0;
    logic [31:0]   cfg_acq_cycles_i = '0;
    logic          hist_config_en_o, hist_reset_o, hist_read_start_o;
    logic [CW-1:0] hist_click_channel_o, hist_start_channel_o;
    logic [SW-1:0] hist_shift_val_o;
    logic [DW-1:0] hist_data_i = '0;
    logic          hist_valid_i = 0;
    logic [DW-1:0] out_data_o;
    logic [IW-1:0] out_index_o;
    logic          out_valid_o, out_last_o, busy_o, frame_done_o, error_o;
    logic [31:0]   frame_count_o;

    int total = 0, fails = 0;
    int n_cfg = 0, n_rst = 0, n_rs = 0;
    int b_cfg, b_rst, b_rs, n;

    histogram_sequencer #(
        .CHANNEL_WIDTH(CW), .SHIFT_WIDTH(SW), .DATA_WIDTH(DW),
        .BIN_COUNT(BINS), .CLEAR_CYCLES(CLR), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .continuous_i(continuous_i),
        .cfg_click_channel_i(cfg_click_channel_i),
        .cfg_start_channel_i(cfg_start_channel_i),
        .cfg_shift_i(cfg_shift_i), .cfg_acq_cycles_i(cfg_acq_cycles_i),
        .hist_config_en_o(hist_config_en_o),
        .hist_click_channel_o(hist_click_channel_o),
        .hist_start_channel_o(hist_start_channel_o),
        .hist_shift_val_o(hist_shift_val_o),
        .hist_reset_o(hist_reset_o), .hist_read_start_o(hist_read_start_o),
        .hist_data_i(hist_data_i), .hist_valid_i(hist_valid_i),
        .out_data_o(out_data_o), .out_index_o(out_index_o),
        .out_valid_o(out_valid_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .error_o(error_o),
        .frame_count_o(frame_count_o)
    );

    always #5 clk = ~clk;

    // Strobe pulse counters, sampled on the edge the DUT itself sees.
    always @(posedge clk) begin
        if (hist_config_en_o)  n_cfg <= n_cfg + 1;
        if (hist_reset_o)      n_rst <= n_rst + 1;
        if (hist_read_start_o) n_rs  <= n_rs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns at the first CONFIG cycle.
    task automatic start_run(input logic [CW-1:0] ck, input logic [CW-1:0] sc,
                             input logic [SW-1:0] sh, input logic [31:0] acq,
                             input logic cont);
        cfg_click_channel_i = ck; cfg_start_channel_i = sc;
        cfg_shift_i = sh; cfg_acq_cycles_i = acq; continuous_i = cont;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_rs(output int cnt);
        cnt = 0;
        while (!hist_read_start_o && cnt < 200) begin
            step();
            cnt++;
        end
        chk("read_start_seen", hist_read_start_o, 1);
    endtask

    // Drive one full frame of beats; returns in the DONE cycle.
    task automatic feed_frame(input int base);
        for (int i = 0; i < BINS; i++) begin
            hist_valid_i = 1'b1;
            hist_data_i  = base + i;
            step();
            chk("out_valid", out_valid_o, 1);
            chk("out_index", out_index_o, i);
            chk("out_data", out_data_o, base + i);
            chk("out_last", out_last_o, (i == BINS - 1));
        end
        hist_valid_i = 1'b0;
        chk("frame_done", frame_done_o, 1);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_busy", busy_o, 0);
        chk("rst_fcount", frame_count_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_outvalid", out_valid_o, 0);
        chk("rst_cfg_en", hist_config_en_o, 0);
        rst_n = 1'b1;
        step();

        // Single frame: config@1, reset@2, read_start@16, 8 beats
        start_run(6'd5, 6'd9, 6'd3, 32'd10, 1'b0);
        chk("t1_cfg_en", hist_config_en_o, 1);
        chk("t1_click", hist_click_channel_o, 5);
        chk("t1_startch", hist_start_channel_o, 9);
        chk("t1_shift", hist_shift_val_o, 3);
        chk("t1_busy", busy_o, 1);
        step();
        chk("t1_hist_reset", hist_reset_o, 1);
        chk("t1_cfg_en_off", hist_config_en_o, 0);
        step();
        chk("t1_hist_reset_off", hist_reset_o, 0);
        wait_rs(n);
        chk("t1_rs_cycle", n, 13);
        feed_frame(100);
        step();
        chk("t1_fdone_off", frame_done_o, 0);
        chk("t1_fcount", frame_count_o, 1);
        chk("t1_idle", busy_o, 0);
        chk("t1_hold_click", hist_click_channel_o, 5);

        // Continuous: three frames, then abort in the following CLEAR
        do_reset();
        b_cfg = n_cfg; b_rst = n_rst;
        start_run(6'd1, 6'd2, 6'd4, 32'd2, 1'b1);
        for (int f = 0; f < 3; f++) begin
            wait_rs(n);
            feed_frame(16 * f);
        end
        step();
        chk("t2_fcount", frame_count_o, 3);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t2_busy", busy_o, 0);
        chk("t2_nreset", n_rst - b_rst, 3);
        chk("t2_ncfg", n_cfg - b_cfg, 1);

        // Abort during ACQUIRE
        start_run(6'd7, 6'd7, 6'd7, 32'd10, 1'b0);
        b_rs = n_rs;
        repeat (6) step();
        chk("t3_busy_acq", busy_o, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t3_busy", busy_o, 0);
        repeat (20) step();
        chk("t3_no_rs", n_rs - b_rs, 0);
        chk("t3_fcount", frame_count_o, 3);

        // Readout timeout, then restart clears error
        start_run(6'd2, 6'd3, 6'd1, 32'd1, 1'b0);
        wait_rs(n);
        repeat (TMO - 1) step();
        chk("t4_err_early", error_o, 0);
        chk("t4_busy_early", busy_o, 1);
        step();
        chk("t4_err", error_o, 1);
        chk("t4_idle", busy_o, 0);
        chk("t4_fcount", frame_count_o, 3);
        start_run(6'd2, 6'd3, 6'd1, 32'd0, 1'b0);
        chk("t4_err_clr", error_o, 0);

        // acq=0: one ACQUIRE cycle; a beat offered there is dropped
        repeat (5) step();
        hist_valid_i = 1'b1;
        hist_data_i  = 32'hdead;
        step();
        hist_valid_i = 1'b0;
        chk("t5_rs_at7", hist_read_start_o, 1);
        chk("t5_no_valid", out_valid_o, 0);
        step();
        chk("t5_no_valid2", out_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            hist_valid_i = 1'b1;
            hist_data_i  = 32'h50 + i;
            step();
            chk("t5_index", out_index_o, i);
        end

        // Reset mid-readout
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_outvalid", out_valid_o, 0);
        chk("t6_index", out_index_o, 0);
        chk("t6_data", out_data_o, 0);
        chk("t6_fcount", frame_count_o, 0);
        chk("t6_click", hist_click_channel_o, 0);
        hist_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_idle", busy_o, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/histogram_sequencer.md
HISTOGRAM_SEQUENCER -- requirements
Module: histogram_sequencer

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 6, width of channel selectors.
REQ-002 SHALL have parameter SHIFT_WIDTH, default 6, width of bin-shift value.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of bin count.
REQ-004 SHALL have parameter BIN_COUNT, default 4096, bins per histogram frame.
REQ-005 SHALL have parameter CLEAR_CYCLES, default 4096, cycles the histogram needs to clear memory.
REQ-006 SHALL have parameter TIMEOUT, default 65535, max idle cycles between readout beats.
REQ-007 SHALL have ports:
  clk  in  1  sole clock.
  rst_n  in  1  asynchronous active-low reset.
  start_i  in  1  pulse that begins a run from IDLE.
  abort_i  in  1  pulse that stops any run.
  continuous_i  in  1  sampled with start_i; re-arm after each frame.
  cfg_click_channel_i  in  CHANNEL_WIDTH  click channel.
  cfg_start_channel_i  in  CHANNEL_WIDTH  start channel.
  cfg_shift_i  in  SHIFT_WIDTH  bin shift.
  cfg_acq_cycles_i  in  32  acquisition window in cycles.
  hist_config_en_o  out  1  config strobe to histogram.
  hist_click_channel_o  out  CHANNEL_WIDTH  latched click channel.
  hist_start_channel_o  out  CHANNEL_WIDTH  latched start channel.
  hist_shift_val_o  out  SHIFT_WIDTH  latched shift.
  hist_reset_o  out  1  histogram clear strobe.
  hist_read_start_o  out  1  histogram readout strobe.
  hist_data_i  in  DATA_WIDTH  readout bin value.
  hist_valid_i  in  1  readout bin valid.
  out_data_o  out  DATA_WIDTH  forwarded bin value.
  out_index_o  out  $clog2(BIN_COUNT)  bin index.
  out_valid_o  out  1  bin valid.
  out_last_o  out  1  last bin of frame.
  busy_o  out  1  high whenever state is not IDLE.
  frame_done_o  out  1  one-cycle pulse per completed frame.
  error_o  out  1  sticky readout timeout; cleared by start_i.
  frame_count_o  out  32  completed frames since reset, wraps at 2^32.

Function
REQ-008 SHALL implement states IDLE, CONFIG, CLEAR, ACQUIRE, READOUT, DONE.
REQ-009 IDLE: on start_i, latch all cfg_* and continuous_i, clear error_o, go to CONFIG next cycle; start_i ignored outside IDLE.
REQ-010 CONFIG: assert hist_config_en_o exactly one cycle with latched values already stable, then go to CLEAR.
REQ-011 CLEAR: assert hist_reset_o on first cycle only, remain CLEAR_CYCLES cycles total, then go to ACQUIRE.
REQ-012 ACQUIRE: remain max(cfg_acq_cycles,1) cycles, then go to READOUT.
REQ-013 READOUT: assert hist_read_start_o on first cycle; count hist_valid_i beats; after BIN_COUNT beats go to DONE.
REQ-014 out_* SHALL register hist_data_i/hist_valid_i with one-cycle latency; out_index_o counts 0..BIN_COUNT-1; out_last_o high with index BIN_COUNT-1; no backpressure.
REQ-015 hist_valid_i outside READOUT SHALL be dropped.
REQ-016 READOUT timeout: TIMEOUT consecutive cycles without hist_valid_i (counted from entry) SHALL set error_o and go to IDLE without frame_done_o.
REQ-017 DONE: pulse frame_done_o one cycle, increment frame_count_o; go to CLEAR if latched continuous, else IDLE.
REQ-018 abort_i in any state SHALL force IDLE next cycle, deassert all strobes and out_valid_o, leave frame_count_o unchanged; abort_i has priority over start_i.
REQ-019 hist_* channel/shift outputs SHALL hold last latched values in IDLE.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE and zero every output and counter; release is synchronised to clk.

Structure
REQ-021 State enum and default constants SHALL reside in shared package histogram_pkg.
REQ-022 One sub-module, seq_timer (load/count-down/expire), SHALL serve CLEAR, ACQUIRE and timeout counting.

Verification
REQ-023 BIN_COUNT=8, CLEAR_CYCLES=4, acq=10, start pulse -> config_en at cycle 1, reset at 2, read_start at 16; 8 beats -> indices 0..7, last on 7, frame_done once, frame_count=1.
REQ-024 continuous=1, three frames -> frame_count=3, hist_reset_o pulses 3 times, config_en once.
REQ-025 abort_i during ACQUIRE -> IDLE next cycle, busy_o=0, no read_start, frame_count unchanged.
REQ-026 TIMEOUT=20, no hist_valid_i in READOUT -> error_o=1 at cycle 20, IDLE; next start_i clears error_o.
REQ-027 cfg_acq_cycles=0 -> ACQUIRE lasts 1 cycle; hist_valid_i injected in ACQUIRE -> no out_valid_o.
REQ-028 rst_n low mid-READOUT -> all outputs 0 immediately, IDLE after release.
